// File: rtl/fully_connect_backward.sv
// Backward pass of a fully-connected layer using one sequential MAC engine.
//   dX = dY * W^T   (batch x feature)
//   dW = X^T * dY   (feature x out)
//   dB = column-sum of dY (out)
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   start         request, accepted only while idle
//   grad_out      dY, element [b][o] at (b*O+o)*32 +: 32
//   data          X,  element [b][f] at (b*F+f)*32 +: 32
//   weight        W,  element [f][o] at (f*O+o)*32 +: 32
//   busy          high whenever the engine is not idle
//   grad_data     dX, packed like data
//   grad_weight   dW, packed like weight
//   grad_bias     dB, element [o] at o*32 +: 32
//   result_valid  one-cycle pulse when all gradient outputs update
// Arithmetic is 32-bit two's complement; products are truncated and sums wrap.
module fully_connect_backward #(
  parameter int unsigned batch_size   = 1,
  parameter int unsigned feature_size = 3,
  parameter int unsigned bias_size    = 2
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  input  logic [batch_size*bias_size*32-1:0]    grad_out,
  input  logic [batch_size*feature_size*32-1:0] data,
  input  logic [feature_size*bias_size*32-1:0]  weight,
  output logic                                 busy,
  output logic [batch_size*feature_size*32-1:0] grad_data,
  output logic [feature_size*bias_size*32-1:0]  grad_weight,
  output logic [bias_size*32-1:0]               grad_bias,
  output logic                                 result_valid
);

  localparam int unsigned B = batch_size;
  localparam int unsigned F = feature_size;
  localparam int unsigned O = bias_size;

  // A dimension of 1 still gets a 1-bit counter that wraps immediately.
  localparam int unsigned BW = (B > 1) ? $clog2(B) : 1;
  localparam int unsigned FW = (F > 1) ? $clog2(F) : 1;
  localparam int unsigned OW = (O > 1) ? $clog2(O) : 1;

  localparam logic [BW-1:0] BMax = BW'(B - 1);
  localparam logic [FW-1:0] FMax = FW'(F - 1);
  localparam logic [OW-1:0] OMax = OW'(O - 1);

  typedef enum logic [2:0] {StIdle, StDx, StDw, StDb, StDone} state_e;

  state_e                state_q;
  logic [B*O*32-1:0]     dy_q;
  logic [B*F*32-1:0]     x_q;
  logic [F*O*32-1:0]     w_q;
  logic [B*F*32-1:0]     dx_sh_q;
  logic [F*O*32-1:0]     dw_sh_q;
  logic [O*32-1:0]       db_sh_q;
  logic [31:0]           acc_q;
  logic [BW-1:0]         cnt_b_q;
  logic [FW-1:0]         cnt_f_q;
  logic [OW-1:0]         cnt_o_q;
  logic [B*F*32-1:0]     grad_data_q;
  logic [F*O*32-1:0]     grad_weight_q;
  logic [O*32-1:0]       grad_bias_q;
  logic                  result_valid_q;

  logic [31:0] dy_e, x_e, w_e;
  logic [31:0] mul_a, mul_b, prod, sum;

  // Operand selection for the single MAC; DB multiplies dY by one.
  always_comb begin
    dy_e  = dy_q[32*(int'(cnt_b_q)*O + int'(cnt_o_q)) +: 32];
    x_e   = x_q[32*(int'(cnt_b_q)*F + int'(cnt_f_q)) +: 32];
    w_e   = w_q[32*(int'(cnt_f_q)*O + int'(cnt_o_q)) +: 32];
    mul_a = 32'd0;
    mul_b = 32'd0;
    unique case (state_q)
      StDx: begin
        mul_a = dy_e;
        mul_b = w_e;
      end
      StDw: begin
        mul_a = x_e;
        mul_b = dy_e;
      end
      StDb: begin
        mul_a = dy_e;
        mul_b = 32'd1;
      end
      default: begin
        mul_a = 32'd0;
        mul_b = 32'd0;
      end
    endcase
    prod = mul_a * mul_b;
    sum  = acc_q + prod;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      dy_q           <= '0;
      x_q            <= '0;
      w_q            <= '0;
      dx_sh_q        <= '0;
      dw_sh_q        <= '0;
      db_sh_q        <= '0;
      acc_q          <= '0;
      cnt_b_q        <= '0;
      cnt_f_q        <= '0;
      cnt_o_q        <= '0;
      grad_data_q    <= '0;
      grad_weight_q  <= '0;
      grad_bias_q    <= '0;
      result_valid_q <= 1'b0;
    end else begin
      result_valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            dy_q    <= grad_out;
            x_q     <= data;
            w_q     <= weight;
            acc_q   <= '0;
            cnt_b_q <= '0;
            cnt_f_q <= '0;
            cnt_o_q <= '0;
            state_q <= StDx;
          end
        end

        // Loop order b, f, o (o innermost).
        StDx: begin
          if (cnt_o_q == OMax) begin
            dx_sh_q[32*(int'(cnt_b_q)*F + int'(cnt_f_q)) +: 32] <= sum;
            acc_q   <= '0;
            cnt_o_q <= '0;
            if (cnt_f_q == FMax) begin
              cnt_f_q <= '0;
              if (cnt_b_q == BMax) begin
                cnt_b_q <= '0;
                state_q <= StDw;
              end else begin
                cnt_b_q <= cnt_b_q + 1'b1;
              end
            end else begin
              cnt_f_q <= cnt_f_q + 1'b1;
            end
          end else begin
            acc_q   <= sum;
            cnt_o_q <= cnt_o_q + 1'b1;
          end
        end

        // Loop order f, o, b (b innermost).
        StDw: begin
          if (cnt_b_q == BMax) begin
            dw_sh_q[32*(int'(cnt_f_q)*O + int'(cnt_o_q)) +: 32] <= sum;
            acc_q   <= '0;
            cnt_b_q <= '0;
            if (cnt_o_q == OMax) begin
              cnt_o_q <= '0;
              if (cnt_f_q == FMax) begin
                cnt_f_q <= '0;
                state_q <= StDb;
              end else begin
                cnt_f_q <= cnt_f_q + 1'b1;
              end
            end else begin
              cnt_o_q <= cnt_o_q + 1'b1;
            end
          end else begin
            acc_q   <= sum;
            cnt_b_q <= cnt_b_q + 1'b1;
          end
        end

        // Loop order o, b (b innermost).
        StDb: begin
          if (cnt_b_q == BMax) begin
            db_sh_q[32*int'(cnt_o_q) +: 32] <= sum;
            acc_q   <= '0;
            cnt_b_q <= '0;
            if (cnt_o_q == OMax) begin
              cnt_o_q <= '0;
              state_q <= StDone;
            end else begin
              cnt_o_q <= cnt_o_q + 1'b1;
            end
          end else begin
            acc_q   <= sum;
            cnt_b_q <= cnt_b_q + 1'b1;
          end
        end

        // Publish shadows in one step so outputs never show partial results.
        StDone: begin
          grad_data_q    <= dx_sh_q;
          grad_weight_q  <= dw_sh_q;
          grad_bias_q    <= db_sh_q;
          result_valid_q <= 1'b1;
          state_q        <= StIdle;
        end

        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy         = (state_q != StIdle);
  assign grad_data    = grad_data_q;
  assign grad_weight  = grad_weight_q;
  assign grad_bias    = grad_bias_q;
  assign result_valid = result_valid_q;

endmodule
